// File: rtl/acc_disp_pkg.sv
// Shared types and default decode tables for the accelerator offload dispatcher.
// The default tables route custom-0 opcodes to accelerators by funct3, one value per accelerator.
package acc_disp_pkg;

  localparam int NumAccMax    = 8;
  localparam int DataWidthMax = 32;
  localparam int RdWidth      = 5;
  localparam int CntWidth     = 4;

  typedef logic [CntWidth-1:0]         cnt_t;
  typedef logic [RdWidth-1:0]          rd_t;
  typedef logic [31:0]                 instr_t;
  typedef logic [NumAccMax-1:0][31:0]  dec_tbl_t;

  typedef struct packed {
    rd_t                     rd;
    logic [DataWidthMax-1:0] data;
    logic                    error;
  } rsp_entry_t;

  localparam instr_t DefaultMask = 32'h0000_707F;

  function automatic dec_tbl_t default_match_tbl();
    dec_tbl_t tbl;
    for (int i = 0; i < NumAccMax; i++) begin
      tbl[i] = 32'h0000_000B | (32'(i) << 12);
    end
    return tbl;
  endfunction

  localparam dec_tbl_t DefaultMatchTbl = default_match_tbl();

endpackage

// File: rtl/acc_disp_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves past
// the granted index only when the caller signals that the grant was consumed.
module acc_disp_rr_arbiter #(
  parameter  int NumReq = 2,
  localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req,
  input  logic              gate,
  input  logic              advance,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx
);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] sel;
  logic            found;

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return IdxW'(sum);
  endfunction

  always_comb begin
    found = 1'b0;
    sel   = ptr;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && req[wrap_idx(ptr, k)]) begin
        found = 1'b1;
        sel   = wrap_idx(ptr, k);
      end
    end
  end

  assign grant     = (found && gate) ? (NumReq'(1) << sel) : '0;
  assign grant_idx = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(sel) == NumReq - 1) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/acc_offload_dispatcher.sv
// Decodes X-interface offload requests onto per-accelerator C channels, tracks rd hazards
// and outstanding offloads, and funnels accelerator responses through a small FIFO.
module acc_offload_dispatcher
  import acc_disp_pkg::*;
#(
  parameter int                      NumAcc         = 2,
  parameter int                      DataWidth      = 32,
  parameter int                      NumRs          = 3,
  parameter int                      MaxOutstanding = 4,
  parameter int                      RspFifoDepth   = 2,
  parameter logic [NumAcc-1:0][31:0] AccMask        = {NumAcc{DefaultMask}},
  parameter logic [NumAcc-1:0][31:0] AccMatch       = DefaultMatchTbl[NumAcc-1:0],
  parameter logic [NumAcc-1:0]       AccWb          = '1,
  parameter logic [31:0]             HartId         = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       x_q_valid_i,
  output logic                       x_q_ready_o,
  input  logic [31:0]                x_q_instr_data_i,
  input  logic [NumRs*DataWidth-1:0] x_q_rs_i,
  input  logic [NumRs-1:0]           x_q_rs_valid_i,
  output logic                       x_k_accept_o,
  output logic                       x_k_writeback_o,
  output logic                       x_p_valid_o,
  input  logic                       x_p_ready_i,
  output logic [4:0]                 x_p_rd_o,
  output logic [DataWidth-1:0]       x_p_data_o,
  output logic                       x_p_error_o,
  output logic [NumAcc-1:0]          c_q_valid_o,
  input  logic [NumAcc-1:0]          c_q_ready_i,
  output logic [31:0]                c_q_instr_data_o,
  output logic [NumRs*DataWidth-1:0] c_q_rs_o,
  output logic [31:0]                c_q_hart_id_o,
  input  logic [NumAcc-1:0]          c_p_valid_i,
  output logic [NumAcc-1:0]          c_p_ready_o,
  input  logic [NumAcc*DataWidth-1:0] c_p_data_i,
  input  logic [NumAcc*5-1:0]        c_p_rd_i,
  input  logic [NumAcc-1:0]          c_p_error_i
);

  localparam int IdxW = (NumAcc > 1) ? $clog2(NumAcc) : 1;
  localparam int PtrW = $clog2(RspFifoDepth);

  logic [NumAcc-1:0] hit;
  logic              any_hit;
  logic [IdxW-1:0]   tgt;
  rd_t               rd;
  logic              wb;
  logic              go;
  logic              accept;
  logic              pop;
  logic              push;
  logic              can_push;

  logic [31:0] pend;
  logic [31:0] pend_next;
  cnt_t        outstanding;

  rsp_entry_t        fifo_mem [RspFifoDepth];
  logic [PtrW-1:0]   rd_ptr;
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW:0]     fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  rsp_entry_t        head;
  rsp_entry_t        push_entry;
  logic [NumAcc-1:0] grant;
  logic [IdxW-1:0]   grant_idx;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NumAcc; i++) begin
      hit[i] = (x_q_instr_data_i & AccMask[i]) == AccMatch[i];
    end
  end

  // Scan downwards so the lowest-index hit is the last one written.
  always_comb begin
    tgt     = '0;
    any_hit = 1'b0;
    for (int i = NumAcc - 1; i >= 0; i--) begin
      if (hit[i]) begin
        tgt     = IdxW'(i);
        any_hit = 1'b1;
      end
    end
  end

  assign rd = x_q_instr_data_i[11:7];
  assign wb = AccWb[tgt] && (rd != '0);
  assign go = (&x_q_rs_valid_i) && (outstanding < cnt_t'(MaxOutstanding)) && !(wb && pend[rd]);

  assign accept           = x_q_valid_i && any_hit && go && c_q_ready_i[tgt];
  assign x_q_ready_o      = any_hit ? (go && c_q_ready_i[tgt]) : 1'b1;
  assign x_k_accept_o     = accept;
  assign x_k_writeback_o  = accept && wb;
  assign c_q_valid_o      = (x_q_valid_i && any_hit && go) ? (NumAcc'(1) << tgt) : '0;
  assign c_q_instr_data_o = x_q_instr_data_i;
  assign c_q_rs_o         = x_q_rs_i;
  assign c_q_hart_id_o    = HartId;

  assign fifo_full  = fifo_cnt == (PtrW + 1)'(RspFifoDepth);
  assign fifo_empty = fifo_cnt == '0;
  assign head       = fifo_mem[rd_ptr];

  assign x_p_valid_o = !fifo_empty;
  assign x_p_rd_o    = head.rd;
  assign x_p_data_o  = head.data[DataWidth-1:0];
  assign x_p_error_o = head.error;

  assign pop      = x_p_valid_o && x_p_ready_i;
  assign can_push = !fifo_full || pop;

  acc_disp_rr_arbiter #(
    .NumReq (NumAcc)
  ) u_arb (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .req       (c_p_valid_i),
    .gate      (can_push),
    .advance   (push),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign c_p_ready_o = grant;
  assign push        = |grant;

  assign push_entry.rd    = c_p_rd_i[grant_idx*RdWidth +: RdWidth];
  assign push_entry.data  = DataWidthMax'(c_p_data_i[grant_idx*DataWidth +: DataWidth]);
  assign push_entry.error = c_p_error_i[grant_idx];

  // When full, a same-cycle pop frees the head slot, which is also the write slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RspFifoDepth; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

  // Applying the set after the clear lets a new writer of the same rd win.
  always_comb begin
    pend_next = pend;
    if (pop) pend_next[x_p_rd_o] = 1'b0;
    if (accept && wb) pend_next[rd] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend        <= '0;
      outstanding <= '0;
    end else begin
      pend <= pend_next;
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  a_outstanding_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding <= cnt_t'(MaxOutstanding));

  a_outstanding_min : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && !accept && outstanding == '0));

endmodule

// File: tb/tb_acc_offload_dispatcher.sv
// Directed bench for acc_offload_dispatcher: hazard stall, reject, outstanding limit,
// round-robin response arbitration, FIFO backpressure and mid-stream reset.
module tb_acc_offload_dispatcher;

  localparam int NumAcc    = 2;
  localparam int DataWidth = 32;
  localparam int NumRs     = 3;

  logic                       clk;
  logic                       rst_n;
  logic                       x_q_valid;
  logic                       x_q_ready;
  logic [31:0]                x_q_instr;
  logic [NumRs*DataWidth-1:0] x_q_rs;
  logic [NumRs-1:0]           x_q_rs_valid;
  logic                       x_k_accept;
  logic                       x_k_writeback;
  logic                       x_p_valid;
  logic                       x_p_ready;
  logic [4:0]                 x_p_rd;
  logic [DataWidth-1:0]       x_p_data;
  logic                       x_p_error;
  logic [NumAcc-1:0]          c_q_valid;
  logic [NumAcc-1:0]          c_q_ready;
  logic [31:0]                c_q_instr;
  logic [NumRs*DataWidth-1:0] c_q_rs;
  logic [31:0]                c_q_hart_id;
  logic [NumAcc-1:0]          c_p_valid;
  logic [NumAcc-1:0]          c_p_ready;
  logic [NumAcc*DataWidth-1:0] c_p_data;
  logic [NumAcc*5-1:0]        c_p_rd;
  logic [NumAcc-1:0]          c_p_error;

  int vec_count   = 0;
  int miscompares = 0;

  acc_offload_dispatcher dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .x_q_valid_i      (x_q_valid),
    .x_q_ready_o      (x_q_ready),
    .x_q_instr_data_i (x_q_instr),
    .x_q_rs_i         (x_q_rs),
    .x_q_rs_valid_i   (x_q_rs_valid),
    .x_k_accept_o     (x_k_accept),
    .x_k_writeback_o  (x_k_writeback),
    .x_p_valid_o      (x_p_valid),
    .x_p_ready_i      (x_p_ready),
    .x_p_rd_o         (x_p_rd),
    .x_p_data_o       (x_p_data),
    .x_p_error_o      (x_p_error),
    .c_q_valid_o      (c_q_valid),
    .c_q_ready_i      (c_q_ready),
    .c_q_instr_data_o (c_q_instr),
    .c_q_rs_o         (c_q_rs),
    .c_q_hart_id_o    (c_q_hart_id),
    .c_p_valid_i      (c_p_valid),
    .c_p_ready_o      (c_p_ready),
    .c_p_data_i       (c_p_data),
    .c_p_rd_i         (c_p_rd),
    .c_p_error_i      (c_p_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mkInstr(input int acc, input int rd);
    return {17'b0, 3'(acc), 5'(rd), 7'h0B};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic q_valid, input logic [31:0] instr,
                               input logic p_ready, input logic [NumAcc-1:0] cp_valid);
    x_q_valid = q_valid;
    x_q_instr = instr;
    x_p_ready = p_ready;
    c_p_valid = cp_valid;
  endtask

  task automatic setRsp(input int acc, input logic [4:0] rd, input logic [31:0] data, input logic err);
    c_p_rd[acc*5 +: 5]                 = rd;
    c_p_data[acc*DataWidth +: DataWidth] = data;
    c_p_error[acc]                     = err;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    x_q_rs       = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    x_q_rs_valid = 3'b111;
    c_q_ready    = 2'b11;
    c_p_data     = '0;
    c_p_rd       = '0;
    c_p_error    = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_x_p_valid", x_p_valid, 0);
    checkOutput("rst_x_p_data", x_p_data, 0);
    checkOutput("rst_c_q_valid", c_q_valid, 0);
    checkOutput("rst_outstanding", dut.outstanding, 0);
    checkOutput("rst_pend", dut.pend, 0);
    tick();
    rst_n = 1'b1;

    // Accept to acc0 with rd=5 in the same cycle it is presented
    applyStimulus(1'b1, mkInstr(0, 5), 1'b0, 2'b00);
    @(negedge clk);
    checkOutput("t1_c_q_valid", c_q_valid, 2'b01);
    checkOutput("t1_ready", x_q_ready, 1);
    checkOutput("t1_accept", x_k_accept, 1);
    checkOutput("t1_wb", x_k_writeback, 1);
    checkOutput("t1_instr_bcast", c_q_instr, 32'h0000_028B);
    checkOutput("t1_rs_bcast", c_q_rs, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    checkOutput("t1_hart_id", c_q_hart_id, 0);
    tick();

    // Same rd again: held until the rd=5 response leaves through x_p
    setRsp(0, 5'd5, 32'hAAAA_0001, 1'b0);
    applyStimulus(1'b1, mkInstr(0, 5), 1'b0, 2'b01);
    @(negedge clk);
    checkOutput("t2_pend5", dut.pend[5], 1);
    checkOutput("t2_outstanding", dut.outstanding, 1);
    checkOutput("t2_held_ready", x_q_ready, 0);
    checkOutput("t2_held_c_q_valid", c_q_valid, 2'b00);
    checkOutput("t2_held_accept", x_k_accept, 0);
    checkOutput("t2_c_p_ready", c_p_ready, 2'b01);
    tick();
    applyStimulus(1'b1, mkInstr(0, 5), 1'b1, 2'b00);
    @(negedge clk);
    checkOutput("t2_x_p_valid", x_p_valid, 1);
    checkOutput("t2_x_p_rd", x_p_rd, 5);
    checkOutput("t2_x_p_data", x_p_data, 32'hAAAA_0001);
    checkOutput("t2_pop_cycle_ready", x_q_ready, 0);
    tick();
    applyStimulus(1'b1, mkInstr(0, 5), 1'b0, 2'b00);
    @(negedge clk);
    checkOutput("t2_pend_cleared", dut.pend, 0);
    checkOutput("t2_after_pop_out", dut.outstanding, 0);
    checkOutput("t2_released_ready", x_q_ready, 1);
    checkOutput("t2_released_accept", x_k_accept, 1);
    checkOutput("t2_released_wb", x_k_writeback, 1);
    tick();

    // Retire that second offload with an error response
    setRsp(0, 5'd5, 32'hAAAA_0002, 1'b1);
    applyStimulus(1'b0, mkInstr(0, 5), 1'b0, 2'b01);
    @(negedge clk);
    checkOutput("t2b_outstanding", dut.outstanding, 1);
    checkOutput("t2b_pend5", dut.pend[5], 1);
    tick();
    applyStimulus(1'b0, mkInstr(0, 5), 1'b1, 2'b00);
    @(negedge clk);
    checkOutput("t2b_x_p_error", x_p_error, 1);
    checkOutput("t2b_x_p_data", x_p_data, 32'hAAAA_0002);
    tick();

    // Unmatched instruction is rejected with no C traffic
    applyStimulus(1'b1, 32'h0000_0013, 1'b0, 2'b00);
    @(negedge clk);
    checkOutput("t3_outstanding_before", dut.outstanding, 0);
    checkOutput("t3_ready", x_q_ready, 1);
    checkOutput("t3_accept", x_k_accept, 0);
    checkOutput("t3_c_q_valid", c_q_valid, 2'b00);
    tick();

    // A missing operand stalls a matching request
    x_q_rs_valid = 3'b011;
    applyStimulus(1'b1, mkInstr(1, 7), 1'b0, 2'b00);
    @(negedge clk);
    checkOutput("t3_outstanding_after", dut.outstanding, 0);
    checkOutput("t3_rs_invalid_ready", x_q_ready, 0);
    checkOutput("t3_rs_invalid_c_q", c_q_valid, 2'b00);
    tick();
    x_q_rs_valid = 3'b111;

    // Fill to MaxOutstanding with rd=0 requests to acc1 (no writeback, no hazard)
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mkInstr(1, 0), 1'b0, 2'b00);
      @(negedge clk);
      checkOutput($sformatf("t4_fill%0d_accept", i), x_k_accept, 1);
      checkOutput($sformatf("t4_fill%0d_c_q", i), c_q_valid, 2'b10);
      checkOutput($sformatf("t4_fill%0d_wb", i), x_k_writeback, 0);
      tick();
    end
    setRsp(1, 5'd0, 32'hBBBB_0001, 1'b0);
    applyStimulus(1'b1, mkInstr(1, 0), 1'b0, 2'b10);
    @(negedge clk);
    checkOutput("t4_full_outstanding", dut.outstanding, 4);
    checkOutput("t4_fifth_ready", x_q_ready, 0);
    checkOutput("t4_fifth_c_q", c_q_valid, 2'b00);
    checkOutput("t4_c_p_ready_a", c_p_ready, 2'b10);
    tick();
    setRsp(1, 5'd0, 32'hBBBB_0002, 1'b0);
    applyStimulus(1'b1, mkInstr(1, 0), 1'b0, 2'b10);
    @(negedge clk);
    checkOutput("t4_still_stalled", x_q_ready, 0);
    checkOutput("t4_c_p_ready_b", c_p_ready, 2'b10);
    tick();
    applyStimulus(1'b1, mkInstr(1, 0), 1'b1, 2'b00);
    @(negedge clk);
    checkOutput("t4_pop1_data", x_p_data, 32'hBBBB_0001);
    checkOutput("t4_pop1_ready", x_q_ready, 0);
    tick();
    applyStimulus(1'b1, mkInstr(1, 0), 1'b1, 2'b00);
    @(negedge clk);
    checkOutput("t4_pop2_data", x_p_data, 32'hBBBB_0002);
    checkOutput("t4_pop_and_accept", x_k_accept, 1);
    tick();
    applyStimulus(1'b1, mkInstr(1, 0), 1'b0, 2'b00);
    @(negedge clk);
    checkOutput("t4_count_unchanged", dut.outstanding, 3);
    checkOutput("t4_refill_accept", x_k_accept, 1);
    tick();
    @(negedge clk);
    checkOutput("t4_refull_outstanding", dut.outstanding, 4);
    checkOutput("t4_refull_ready", x_q_ready, 0);
    tick();

    // Both accelerators respond every cycle; grants alternate starting at acc0
    setRsp(0, 5'd1, 32'h1000_0000, 1'b0);
    setRsp(1, 5'd2, 32'h2000_0000, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 2'b11);
    @(negedge clk);
    checkOutput("t5_grant0", c_p_ready, 2'b01);
    tick();
    @(negedge clk);
    checkOutput("t5_grant1", c_p_ready, 2'b10);
    checkOutput("t5_head1_data", x_p_data, 32'h1000_0000);
    checkOutput("t5_head1_rd", x_p_rd, 1);
    tick();
    @(negedge clk);
    checkOutput("t5_grant2", c_p_ready, 2'b01);
    checkOutput("t5_head2_data", x_p_data, 32'h2000_0000);
    checkOutput("t5_head2_rd", x_p_rd, 2);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge clk);
    checkOutput("t5_head3_valid", x_p_valid, 1);
    checkOutput("t5_head3_data", x_p_data, 32'h1000_0000);
    tick();

    // Backpressure from the core fills the FIFO, then reset drops everything
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11);
    @(negedge clk);
    checkOutput("t6_drained", x_p_valid, 0);
    checkOutput("t6_outstanding", dut.outstanding, 1);
    checkOutput("t6_grant_a", c_p_ready, 2'b10);
    tick();
    @(negedge clk);
    checkOutput("t6_grant_b", c_p_ready, 2'b01);
    checkOutput("t6_head_data_a", x_p_data, 32'h2000_0000);
    tick();
    @(negedge clk);
    checkOutput("t6_full_c_p_ready", c_p_ready, 2'b00);
    checkOutput("t6_full_valid", x_p_valid, 1);
    checkOutput("t6_full_data", x_p_data, 32'h2000_0000);
    checkOutput("t6_full_rd", x_p_rd, 2);
    tick();
    @(negedge clk);
    checkOutput("t6_stable_data", x_p_data, 32'h2000_0000);
    checkOutput("t6_stable_c_p_ready", c_p_ready, 2'b00);
    tick();
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b00);
    @(negedge clk);
    checkOutput("t6_rst_x_p_valid", x_p_valid, 0);
    checkOutput("t6_rst_x_p_data", x_p_data, 0);
    checkOutput("t6_rst_x_p_rd", x_p_rd, 0);
    checkOutput("t6_rst_x_p_error", x_p_error, 0);
    checkOutput("t6_rst_c_p_ready", c_p_ready, 2'b00);
    checkOutput("t6_rst_c_q_valid", c_q_valid, 2'b00);
    checkOutput("t6_rst_accept", x_k_accept, 0);
    checkOutput("t6_rst_outstanding", dut.outstanding, 0);
    checkOutput("t6_rst_pend", dut.pend, 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, mkInstr(1, 9), 1'b0, 2'b00);
    @(negedge clk);
    checkOutput("t6_post_rst_c_q", c_q_valid, 2'b10);
    checkOutput("t6_post_rst_accept", x_k_accept, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
